// File: rtl/fauftb_s2_npc.sv
// Stage-2 next-PC resolver behind the micro-FTB: registers the s1 prediction,
// picks the taken slot, forms the next fetch PC and issues a one-shot s0 redirect.
module fauftb_s2_npc #(
    parameter int PC_W        = 41,
    parameter int META_W      = 223,
    parameter int FETCH_BYTES = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_s1_fire,
    input  logic              io_s2_fire,
    input  logic              io_flush,
    input  logic [PC_W-1:0]   io_in_pc,
    input  logic              io_in_hit,
    input  logic              io_in_slot_valids_0,
    input  logic              io_in_slot_valids_1,
    input  logic              io_in_br_taken_mask_0,
    input  logic              io_in_br_taken_mask_1,
    input  logic [PC_W-1:0]   io_in_targets_0,
    input  logic [PC_W-1:0]   io_in_targets_1,
    input  logic [3:0]        io_in_offsets_0,
    input  logic [3:0]        io_in_offsets_1,
    input  logic [PC_W-1:0]   io_in_fallThroughAddr,
    input  logic              io_in_is_br_sharing,
    input  logic [META_W-1:0] io_in_meta,
    input  logic              io_s1_valid,
    input  logic [PC_W-1:0]   io_s1_pc,
    output logic              io_s2_valid,
    output logic [PC_W-1:0]   io_s2_pc,
    output logic [PC_W-1:0]   io_s2_npc,
    output logic              io_s2_taken,
    output logic [3:0]        io_s2_cfi_offset,
    output logic              io_s2_hit,
    output logic [META_W-1:0] io_s2_meta,
    output logic              io_redirect_valid,
    output logic [PC_W-1:0]   io_redirect_pc,
    output logic [5:0]        io_perf_hit,
    output logic [5:0]        io_perf_redirect
);

    logic              s2_valid;
    logic [PC_W-1:0]   pc_q;
    logic              hit_q;
    logic              sv0_q, sv1_q, tm0_q, tm1_q, share_q;
    logic [PC_W-1:0]   tgt0_q, tgt1_q, fta_q;
    logic [3:0]        off0_q, off1_q;
    logic [META_W-1:0] meta_q;
    logic              rd_done;
    logic [5:0]        perf_hit_q, perf_rd_q;

    logic              t0, t1, load, redirect;
    logic [PC_W-1:0]   npc;

    assign load = io_s1_fire & ~io_flush;

    // A tail slot that is not sharing with a branch holds a jump: always taken.
    assign t0 = sv0_q & tm0_q;
    assign t1 = sv1_q & (share_q ? tm1_q : 1'b1);

    always_comb begin
        npc = pc_q + PC_W'(FETCH_BYTES);
        if (hit_q) begin
            if (t0)      npc = tgt0_q;
            else if (t1) npc = tgt1_q;
            else         npc = fta_q;
        end
    end

    assign redirect = s2_valid & ~rd_done & ~io_flush & io_s1_valid & (io_s1_pc != npc);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            pc_q     <= '0;
            hit_q    <= 1'b0;
            sv0_q    <= 1'b0;
            sv1_q    <= 1'b0;
            tm0_q    <= 1'b0;
            tm1_q    <= 1'b0;
            share_q  <= 1'b0;
            tgt0_q   <= '0;
            tgt1_q   <= '0;
            fta_q    <= '0;
            off0_q   <= '0;
            off1_q   <= '0;
            meta_q   <= '0;
        end else begin
            if (io_flush)        s2_valid <= 1'b0;
            else if (io_s1_fire) s2_valid <= 1'b1;
            else if (io_s2_fire) s2_valid <= 1'b0;
            if (load) begin
                pc_q    <= io_in_pc;
                hit_q   <= io_in_hit;
                sv0_q   <= io_in_slot_valids_0;
                sv1_q   <= io_in_slot_valids_1;
                tm0_q   <= io_in_br_taken_mask_0;
                tm1_q   <= io_in_br_taken_mask_1;
                share_q <= io_in_is_br_sharing;
                tgt0_q  <= io_in_targets_0;
                tgt1_q  <= io_in_targets_1;
                fta_q   <= io_in_fallThroughAddr;
                off0_q  <= io_in_offsets_0;
                off1_q  <= io_in_offsets_1;
                meta_q  <= io_in_meta;
            end
        end
    end

    // One redirect per s2 occupancy; a fresh load re-arms it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                rd_done <= 1'b0;
        else if (io_flush | load) rd_done <= 1'b0;
        else if (redirect)        rd_done <= 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_hit_q <= '0;
            perf_rd_q  <= '0;
        end else begin
            if (s2_valid & io_s2_fire & hit_q & (perf_hit_q != 6'd63))
                perf_hit_q <= perf_hit_q + 6'd1;
            if (redirect & (perf_rd_q != 6'd63))
                perf_rd_q <= perf_rd_q + 6'd1;
        end
    end

    assign io_s2_valid       = s2_valid;
    assign io_s2_pc          = pc_q;
    assign io_s2_npc         = s2_valid ? npc : '0;
    assign io_s2_taken       = hit_q & (t0 | t1);
    assign io_s2_cfi_offset  = t0 ? off0_q : (t1 ? off1_q : 4'd0);
    assign io_s2_hit         = hit_q;
    assign io_s2_meta        = meta_q;
    assign io_redirect_valid = redirect;
    assign io_redirect_pc    = io_s2_npc;
    assign io_perf_hit       = perf_hit_q;
    assign io_perf_redirect  = perf_rd_q;

endmodule

// File: tb/tb_fauftb_s2_npc.sv
// Directed bench for fauftb_s2_npc: table of captured predictions plus
// hand-written redirect, flush, saturation and async-reset sequences.
module tb_fauftb_s2_npc;

    localparam int PC_W   = 41;
    localparam int META_W = 223;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_s1_fire, io_s2_fire, io_flush;
    logic [PC_W-1:0]   io_in_pc;
    logic              io_in_hit;
    logic              io_in_slot_valids_0, io_in_slot_valids_1;
    logic              io_in_br_taken_mask_0, io_in_br_taken_mask_1;
    logic [PC_W-1:0]   io_in_targets_0, io_in_targets_1;
    logic [3:0]        io_in_offsets_0, io_in_offsets_1;
    logic [PC_W-1:0]   io_in_fallThroughAddr;
    logic              io_in_is_br_sharing;
    logic [META_W-1:0] io_in_meta;
    logic              io_s1_valid;
    logic [PC_W-1:0]   io_s1_pc;
    logic              io_s2_valid;
    logic [PC_W-1:0]   io_s2_pc, io_s2_npc;
    logic              io_s2_taken;
    logic [3:0]        io_s2_cfi_offset;
    logic              io_s2_hit;
    logic [META_W-1:0] io_s2_meta;
    logic              io_redirect_valid;
    logic [PC_W-1:0]   io_redirect_pc;
    logic [5:0]        io_perf_hit, io_perf_redirect;

    fauftb_s2_npc dut (
        .clock(clock), .reset(reset),
        .io_s1_fire(io_s1_fire), .io_s2_fire(io_s2_fire), .io_flush(io_flush),
        .io_in_pc(io_in_pc), .io_in_hit(io_in_hit),
        .io_in_slot_valids_0(io_in_slot_valids_0), .io_in_slot_valids_1(io_in_slot_valids_1),
        .io_in_br_taken_mask_0(io_in_br_taken_mask_0), .io_in_br_taken_mask_1(io_in_br_taken_mask_1),
        .io_in_targets_0(io_in_targets_0), .io_in_targets_1(io_in_targets_1),
        .io_in_offsets_0(io_in_offsets_0), .io_in_offsets_1(io_in_offsets_1),
        .io_in_fallThroughAddr(io_in_fallThroughAddr), .io_in_is_br_sharing(io_in_is_br_sharing),
        .io_in_meta(io_in_meta), .io_s1_valid(io_s1_valid), .io_s1_pc(io_s1_pc),
        .io_s2_valid(io_s2_valid), .io_s2_pc(io_s2_pc), .io_s2_npc(io_s2_npc),
        .io_s2_taken(io_s2_taken), .io_s2_cfi_offset(io_s2_cfi_offset), .io_s2_hit(io_s2_hit),
        .io_s2_meta(io_s2_meta), .io_redirect_valid(io_redirect_valid),
        .io_redirect_pc(io_redirect_pc), .io_perf_hit(io_perf_hit),
        .io_perf_redirect(io_perf_redirect)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            hit, sv0, sv1, tm0, tm1, share;
        logic [PC_W-1:0] tg0, tg1, fta;
        logic [3:0]      o0, o1;
        logic [PC_W-1:0] e_npc;
        logic            e_taken;
        logic [3:0]      e_off;
    } vec_t;

    vec_t vecs[7];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_block(input vec_t v, input logic [META_W-1:0] meta);
        io_in_pc              = v.pc;
        io_in_hit             = v.hit;
        io_in_slot_valids_0   = v.sv0;
        io_in_slot_valids_1   = v.sv1;
        io_in_br_taken_mask_0 = v.tm0;
        io_in_br_taken_mask_1 = v.tm1;
        io_in_is_br_sharing   = v.share;
        io_in_targets_0       = v.tg0;
        io_in_targets_1       = v.tg1;
        io_in_fallThroughAddr = v.fta;
        io_in_offsets_0       = v.o0;
        io_in_offsets_1       = v.o1;
        io_in_meta            = meta;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s2_valid"}, 64'(io_s2_valid), 64'd0);
        chk({tag, "_npc"}, 64'(io_s2_npc), 64'd0);
        chk({tag, "_redirect"}, 64'(io_redirect_valid), 64'd0);
        chk({tag, "_perf_hit"}, 64'(io_perf_hit), 64'd0);
        chk({tag, "_perf_rd"}, 64'(io_perf_redirect), 64'd0);
        chk({tag, "_s2_pc"}, 64'(io_s2_pc), 64'd0);
        chk({tag, "_taken"}, 64'(io_s2_taken), 64'd0);
    endtask

    vec_t blk;

    initial begin
        //             pc                 hit sv0 sv1 tm0 tm1 sh  tg0       tg1       fta       o0 o1  e_npc              tk off
        vecs[0] = '{41'h0_8000_0000,      0, 0, 0, 0, 0, 0, 41'h0,    41'h0,    41'h0,    0, 0, 41'h0_8000_0020,   0, 0};
        vecs[1] = '{41'h100,              1, 1, 1, 1, 1, 1, 41'h1000, 41'h2000, 41'h1040, 3, 9, 41'h1000,          1, 3};
        vecs[2] = '{41'h100,              1, 1, 1, 0, 0, 0, 41'h1000, 41'h2000, 41'h1040, 3, 9, 41'h2000,          1, 9};
        vecs[3] = '{41'h200,              1, 1, 1, 0, 0, 1, 41'h1000, 41'h2000, 41'h3000, 3, 9, 41'h3000,          0, 0};
        vecs[4] = '{41'h300,              1, 0, 1, 1, 1, 1, 41'h1000, 41'h2000, 41'h3100, 3, 9, 41'h2000,          1, 9};
        vecs[5] = '{41'h1FF_FFFF_FFF0,    0, 0, 0, 0, 0, 0, 41'h0,    41'h0,    41'h0,    0, 0, 41'h10,            0, 0};
        vecs[6] = '{41'h400,              1, 0, 0, 1, 0, 0, 41'h1000, 41'h2000, 41'h4444, 5, 6, 41'h4444,          0, 0};

        reset = 1'b1;
        io_s1_fire = 0; io_s2_fire = 0; io_flush = 0; io_s1_valid = 0; io_s1_pc = '0;
        drive_block(vecs[0], '0);
        #1 chk_all_zero("reset");
        @(negedge clock); @(negedge clock);
        reset = 1'b0;

        // Table: capture one block per vector, check it the following cycle.
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            drive_block(vecs[i], META_W'(i * 3 + 1));
            io_s1_fire = 1;
            @(posedge clock); #1;
            io_s1_fire = 0;
            chk($sformatf("v%0d_s2_valid", i), 64'(io_s2_valid), 64'd1);
            chk($sformatf("v%0d_s2_pc", i), 64'(io_s2_pc), 64'(vecs[i].pc));
            chk($sformatf("v%0d_hit", i), 64'(io_s2_hit), 64'(vecs[i].hit));
            chk($sformatf("v%0d_npc", i), 64'(io_s2_npc), 64'(vecs[i].e_npc));
            chk($sformatf("v%0d_taken", i), 64'(io_s2_taken), 64'(vecs[i].e_taken));
            chk($sformatf("v%0d_offset", i), 64'(io_s2_cfi_offset), 64'(vecs[i].e_off));
            chk($sformatf("v%0d_meta", i), 64'(io_s2_meta), 64'(i * 3 + 1));
        end

        // Redirect: mismatch fires for exactly one cycle while s2 holds.
        blk = vecs[1]; blk.pc = 41'h800;
        @(negedge clock);
        drive_block(blk, '0); io_s1_fire = 1;
        @(negedge clock);
        io_s1_fire = 0; io_s1_valid = 1; io_s1_pc = 41'h1020;
        #1;
        chk("rd_first_valid", 64'(io_redirect_valid), 64'd1);
        chk("rd_first_pc", 64'(io_redirect_pc), 64'h1000);
        @(negedge clock); #1;
        chk("rd_oneshot", 64'(io_redirect_valid), 64'd0);
        chk("rd_s2_holds", 64'(io_s2_valid), 64'd1);
        chk("rd_count", 64'(io_perf_redirect), 64'd1);
        @(negedge clock);
        io_s1_valid = 0; io_s1_fire = 1;
        @(negedge clock);
        io_s1_fire = 0; io_s1_valid = 1; io_s1_pc = 41'h1000;
        #1 chk("rd_match_none", 64'(io_redirect_valid), 64'd0);

        // Flush with s1_fire: invalidates and does not capture.
        @(negedge clock);
        io_s1_valid = 0; io_flush = 1; io_s1_fire = 1;
        blk = vecs[3]; drive_block(blk, '0);
        @(negedge clock);
        io_flush = 0; io_s1_fire = 0;
        #1;
        chk("flush_fire_valid", 64'(io_s2_valid), 64'd0);
        chk("flush_no_capture", 64'(io_s2_pc), 64'h800);
        chk("flush_npc_gated", 64'(io_s2_npc), 64'd0);
        // Flush while valid with a pending mismatch: no redirect, s2 cleared.
        @(negedge clock);
        blk = vecs[1]; drive_block(blk, '0); io_s1_fire = 1;
        @(negedge clock);
        io_s1_fire = 0; io_s1_valid = 1; io_s1_pc = 41'h1020; io_flush = 1;
        #1 chk("flush_kills_rd", 64'(io_redirect_valid), 64'd0);
        @(negedge clock);
        io_flush = 0; io_s1_valid = 0;
        #1;
        chk("flush_clears", 64'(io_s2_valid), 64'd0);
        chk("flush_rd_count", 64'(io_perf_redirect), 64'd1);

        // Saturation: 70 consumed hits, each cycle refilled by s1_fire.
        @(negedge clock);
        drive_block(vecs[1], '0); io_s1_fire = 1;
        @(negedge clock);
        io_s2_fire = 1;
        for (int k = 0; k < 70; k++) @(negedge clock);
        io_s1_fire = 0; io_s2_fire = 0;
        #1;
        chk("sat_perf_hit", 64'(io_perf_hit), 64'd63);
        chk("sat_valid", 64'(io_s2_valid), 64'd1);

        // Async reset in the middle of a cycle while s2 is occupied.
        #2 reset = 1'b1;
        #1 chk_all_zero("areset");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk_all_zero("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
